// File: rtl/rfic_mcs_seq_pkg.sv
// rtl/rfic_mcs_seq_pkg.sv - shared types and helpers for the RFIC MCS sequencer
// Purpose: sequencer state encoding and the timing down-counter width helper.
// Ports: none (package rfic_mcs_pkg).
package rfic_mcs_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST_ASSERT,
    RST_WAIT,
    SYNC_HIGH,
    SYNC_GAP,
    DONE
  } state_e;

  // One counter serves every timed state, so size it for the longest one.
  function automatic int cnt_width(int a, int b, int c, int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/rfic_mcs_seq_if.sv
// rtl/rfic_mcs_seq_if.sv - command/status bundle between GPIO block and sequencer
// Purpose: groups the sequence commands and the sequencer status flags.
// Signals: cmd_reset, cmd_sync (1-cycle pulses), chip_mask (per chip),
//          busy, done (1-cycle pulse), cmd_dropped (sticky).
// Modports: master = command issuer, slave = sequencer.
interface rfic_mcs_seq_if #(
  parameter int NUM_RFIC = 2
);
  logic                cmd_reset;
  logic                cmd_sync;
  logic [NUM_RFIC-1:0] chip_mask;
  logic                busy;
  logic                done;
  logic                cmd_dropped;

  modport master (
    output cmd_reset, cmd_sync, chip_mask,
    input  busy, done, cmd_dropped
  );

  modport slave (
    input  cmd_reset, cmd_sync, chip_mask,
    output busy, done, cmd_dropped
  );
endinterface

// File: rtl/rfic_mcs_seq_status_sync.sv
// rtl/rfic_mcs_seq_status_sync.sv - per-chip CTRL_OUT synchroniser with optional edge capture
// Purpose: 2-flop synchroniser per status bit; with RFIC_MCS_STATUS_IRQ_EN also
//          captures rising edges of unmasked bits into sticky source bits.
// Ports: clk, rst, status_i (async), status_o (synchronised);
//        optional: chip_rst_i, irq_mask_i, irq_clr_i, irq_src_o.
module rfic_status_sync #(
  parameter int STATUS_W = 8
) (
  input  logic                clk,
  input  logic                rst,
`ifdef RFIC_MCS_STATUS_IRQ_EN
  input  logic                chip_rst_i,
  input  logic [STATUS_W-1:0] irq_mask_i,
  input  logic                irq_clr_i,
  output logic [STATUS_W-1:0] irq_src_o,
`endif
  input  logic [STATUS_W-1:0] status_i,
  output logic [STATUS_W-1:0] status_o
);

  logic [STATUS_W-1:0] meta_q;
  logic [STATUS_W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= status_i;
      sync_q <= meta_q;
    end
  end

  assign status_o = sync_q;

`ifdef RFIC_MCS_STATUS_IRQ_EN
  logic [STATUS_W-1:0] prev_q;
  logic [STATUS_W-1:0] src_q;
  logic [STATUS_W-1:0] src_d;
  logic [STATUS_W-1:0] rise;

  assign rise = sync_q & ~prev_q & ~irq_mask_i;

  // Clear is applied before OR-ing in new edges so a same-cycle edge survives.
  always_comb begin
    src_d = irq_clr_i ? '0 : src_q;
    src_d = src_d | rise;
    if (chip_rst_i) src_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      src_q  <= '0;
    end else begin
      prev_q <= sync_q;
      src_q  <= src_d;
    end
  end

  assign irq_src_o = src_q;
`endif

endmodule

// File: rtl/rfic_mcs_seq.sv
// rtl/rfic_mcs_seq.sv - reset/MCS-sync sequencer and control gating for AD9361-class RFICs
// Purpose: timed per-chip resetb release, multi-pulse shared mcs_sync, gated
//          ENABLE/TXNRX/EN_AGC/CTRL_IN, synchronised CTRL_OUT.
// Ports: clk, rst (sync, active-high); cmd_if (slave: commands, busy/done/cmd_dropped);
//        sw_*_i software requests; status_in_i async status; resetb_o, mcs_sync_o,
//        enable_o, txnrx_o, en_agc_o, ctl_o, status_out_o.
// Option: RFIC_MCS_STATUS_IRQ_EN adds status_irq_mask_i, status_irq_clr_i,
//         status_irq_o and status_irq_src_o.
module rfic_mcs_seq
  import rfic_mcs_pkg::*;
#(
  parameter int NUM_RFIC          = 2,
  parameter int STATUS_W          = 8,
  parameter int CTL_W             = 4,
  parameter int RESET_CYCLES      = 1000,
  parameter int POST_RESET_CYCLES = 5000,
  parameter int SYNC_PULSES       = 3,
  parameter int SYNC_HIGH_CYCLES  = 8,
  parameter int SYNC_GAP_CYCLES   = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  rfic_mcs_seq_if.slave                cmd_if,
  input  logic [NUM_RFIC-1:0]          sw_enable_i,
  input  logic [NUM_RFIC-1:0]          sw_txnrx_i,
  input  logic [NUM_RFIC-1:0]          sw_en_agc_i,
  input  logic [NUM_RFIC*CTL_W-1:0]    sw_ctl_i,
  input  logic [NUM_RFIC*STATUS_W-1:0] status_in_i,
`ifdef RFIC_MCS_STATUS_IRQ_EN
  input  logic [NUM_RFIC*STATUS_W-1:0] status_irq_mask_i,
  input  logic                         status_irq_clr_i,
  output logic                         status_irq_o,
  output logic [NUM_RFIC*STATUS_W-1:0] status_irq_src_o,
`endif
  output logic [NUM_RFIC-1:0]          resetb_o,
  output logic                         mcs_sync_o,
  output logic [NUM_RFIC-1:0]          enable_o,
  output logic [NUM_RFIC-1:0]          txnrx_o,
  output logic [NUM_RFIC-1:0]          en_agc_o,
  output logic [NUM_RFIC*CTL_W-1:0]    ctl_o,
  output logic [NUM_RFIC*STATUS_W-1:0] status_out_o
);

  localparam int CW = cnt_width(RESET_CYCLES, POST_RESET_CYCLES,
                                SYNC_HIGH_CYCLES, SYNC_GAP_CYCLES);
  typedef logic [CW-1:0] cnt_t;
  // Counter is loaded with N-1 and the state exits on zero: exactly N cycles.
  localparam cnt_t RST_LD  = cnt_t'(RESET_CYCLES - 1);
  localparam cnt_t POST_LD = cnt_t'(POST_RESET_CYCLES - 1);
  localparam cnt_t HIGH_LD = cnt_t'(SYNC_HIGH_CYCLES - 1);
  localparam cnt_t GAP_LD  = cnt_t'(SYNC_GAP_CYCLES - 1);

  state_e                state_q, state_d;
  cnt_t                  cnt_q, cnt_d;
  logic [NUM_RFIC-1:0]   mask_q, mask_d;
  logic [3:0]            pulse_q, pulse_d;
  logic                  dropped_q, dropped_d;
  logic [NUM_RFIC-1:0]   resetb_q, resetb_d;
  logic [NUM_RFIC-1:0]   enable_q, enable_d;
  logic [NUM_RFIC-1:0]   txnrx_q, txnrx_d;
  logic [NUM_RFIC-1:0]   en_agc_q, en_agc_d;
  logic [NUM_RFIC*CTL_W-1:0] ctl_q, ctl_d;
  logic                  mcs_q, busy_q, done_q;
  logic                  seq_busy;
  logic                  gate_phase;

  assign seq_busy = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    pulse_d   = pulse_q;
    dropped_d = dropped_q;

    // A sync request is dropped only when it is not carried by a cmd_reset.
    if (cmd_if.cmd_sync && !cmd_if.cmd_reset && seq_busy) dropped_d = 1'b1;

    if (cmd_if.cmd_reset) begin
      state_d   = RST_ASSERT;
      cnt_d     = RST_LD;
      mask_d    = cmd_if.chip_mask;
      dropped_d = 1'b0;
    end else if (cmd_if.cmd_sync && !seq_busy) begin
      state_d = SYNC_HIGH;
      cnt_d   = HIGH_LD;
      pulse_d = '0;
    end else begin
      case (state_q)
        IDLE: ;
        RST_ASSERT:
          if (cnt_q == '0) begin
            state_d = RST_WAIT;
            cnt_d   = POST_LD;
          end else cnt_d = cnt_q - cnt_t'(1);
        RST_WAIT:
          if (cnt_q == '0) begin
            state_d = SYNC_HIGH;
            cnt_d   = HIGH_LD;
            pulse_d = '0;
          end else cnt_d = cnt_q - cnt_t'(1);
        SYNC_HIGH:
          if (cnt_q == '0) begin
            state_d = SYNC_GAP;
            cnt_d   = GAP_LD;
            pulse_d = pulse_q + 4'd1;
          end else cnt_d = cnt_q - cnt_t'(1);
        SYNC_GAP:
          if (cnt_q == '0) begin
            if (pulse_q < 4'(SYNC_PULSES)) begin
              state_d = SYNC_HIGH;
              cnt_d   = HIGH_LD;
            end else state_d = DONE;
          end else cnt_d = cnt_q - cnt_t'(1);
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are derived from the next state so each register lines up with its state.
  always_comb begin
    resetb_d = resetb_q;
    if (state_d == RST_ASSERT)    resetb_d = resetb_q & ~mask_d;
    else if (state_d == RST_WAIT) resetb_d = resetb_q | mask_d;

    gate_phase = (state_d == RST_WAIT) || (state_d == SYNC_HIGH) || (state_d == SYNC_GAP);
    enable_d = '0;
    txnrx_d  = '0;
    en_agc_d = '0;
    ctl_d    = '0;
    for (int i = 0; i < NUM_RFIC; i++) begin
      if (resetb_d[i] && !gate_phase) begin
        enable_d[i] = sw_enable_i[i];
        txnrx_d[i]  = sw_txnrx_i[i];
        en_agc_d[i] = sw_en_agc_i[i];
        ctl_d[i*CTL_W +: CTL_W] = sw_ctl_i[i*CTL_W +: CTL_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RST_ASSERT;
      cnt_q     <= RST_LD;
      mask_q    <= '1;
      pulse_q   <= '0;
      dropped_q <= 1'b0;
      resetb_q  <= '0;
      enable_q  <= '0;
      txnrx_q   <= '0;
      en_agc_q  <= '0;
      ctl_q     <= '0;
      mcs_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      pulse_q   <= pulse_d;
      dropped_q <= dropped_d;
      resetb_q  <= resetb_d;
      enable_q  <= enable_d;
      txnrx_q   <= txnrx_d;
      en_agc_q  <= en_agc_d;
      ctl_q     <= ctl_d;
      mcs_q     <= (state_d == SYNC_HIGH);
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
    end
  end

  assign resetb_o           = resetb_q;
  assign mcs_sync_o         = mcs_q;
  assign enable_o           = enable_q;
  assign txnrx_o            = txnrx_q;
  assign en_agc_o           = en_agc_q;
  assign ctl_o              = ctl_q;
  assign cmd_if.busy        = busy_q;
  assign cmd_if.done        = done_q;
  assign cmd_if.cmd_dropped = dropped_q;

`ifdef RFIC_MCS_STATUS_IRQ_EN
  logic [NUM_RFIC*STATUS_W-1:0] src_all;
  assign status_irq_src_o = src_all;
  assign status_irq_o     = |src_all;
`endif

  for (genvar g = 0; g < NUM_RFIC; g++) begin : g_chip
    rfic_status_sync #(.STATUS_W(STATUS_W)) u_sync (
      .clk        (clk),
      .rst        (rst),
`ifdef RFIC_MCS_STATUS_IRQ_EN
      .chip_rst_i (~resetb_q[g]),
      .irq_mask_i (status_irq_mask_i[g*STATUS_W +: STATUS_W]),
      .irq_clr_i  (status_irq_clr_i),
      .irq_src_o  (src_all[g*STATUS_W +: STATUS_W]),
`endif
      .status_i   (status_in_i[g*STATUS_W +: STATUS_W]),
      .status_o   (status_out_o[g*STATUS_W +: STATUS_W])
    );
  end

endmodule

// File: tb/tb_rfic_mcs_seq.sv
// tb/tb_rfic_mcs_seq.sv - scoreboard bench for rfic_mcs_seq
module tb_rfic_mcs_seq;
  localparam int R = 10, P = 20, NP = 3, H = 4, G = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  sw_enable = 2'b01, sw_txnrx = 2'b01, sw_en_agc = 2'b00;
  logic [7:0]  sw_ctl = 8'h00;
  logic [15:0] status_in = 16'h0000;
  logic [1:0]  resetb, enable, txnrx, en_agc;
  logic [7:0]  ctl;
  logic [15:0] status_out;
  logic        mcs_sync;
`ifdef RFIC_MCS_STATUS_IRQ_EN
  logic [15:0] irq_mask = 16'h0000;
  logic        irq_clr = 1'b0;
  logic        irq;
  logic [15:0] irq_src;
`endif

  rfic_mcs_seq_if #(.NUM_RFIC(2)) bus ();

  rfic_mcs_seq #(
    .NUM_RFIC(2), .STATUS_W(8), .CTL_W(4), .RESET_CYCLES(R), .POST_RESET_CYCLES(P),
    .SYNC_PULSES(NP), .SYNC_HIGH_CYCLES(H), .SYNC_GAP_CYCLES(G)
  ) dut (
    .clk(clk), .rst(rst), .cmd_if(bus.slave),
    .sw_enable_i(sw_enable), .sw_txnrx_i(sw_txnrx), .sw_en_agc_i(sw_en_agc),
    .sw_ctl_i(sw_ctl), .status_in_i(status_in),
`ifdef RFIC_MCS_STATUS_IRQ_EN
    .status_irq_mask_i(irq_mask), .status_irq_clr_i(irq_clr),
    .status_irq_o(irq), .status_irq_src_o(irq_src),
`endif
    .resetb_o(resetb), .mcs_sync_o(mcs_sync), .enable_o(enable), .txnrx_o(txnrx),
    .en_agc_o(en_agc), .ctl_o(ctl), .status_out_o(status_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Event kinds: 2*chip = resetb fall, 2*chip+1 = resetb rise,
  // 4 mcs rise, 5 mcs fall, 6 done rise, 7 done fall.
  typedef struct {
    int kind;
    int cyc;
  } ev_t;
  ev_t exp_q[$];
  logic [1:0] rb_model = 2'b00;

  task automatic push_ev(input int k, input int c);
    ev_t e;
    int  i;
    i = 0;
    while (i < exp_q.size() && (exp_q[i].cyc < c || (exp_q[i].cyc == c && exp_q[i].kind <= k)))
      i++;
    e.kind = k;
    e.cyc  = c;
    exp_q.insert(i, e);
  endtask

  task automatic purge(input int a);
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (exp_q[i].cyc >= a) exp_q.delete(i);
  endtask

  // a = edge at which the command takes effect.
  task automatic push_seq(input int a, input logic [1:0] mask, input bit with_rst);
    int s;
    s = a;
    if (with_rst) begin
      for (int i = 0; i < 2; i++) begin
        if (mask[i]) begin
          if (rb_model[i]) push_ev(2 * i, a);
          push_ev(2 * i + 1, a + R);
          rb_model[i] = 1'b1;
        end
      end
      s = a + R + P;
    end
    for (int k = 0; k < NP; k++) begin
      push_ev(4, s + k * (H + G));
      push_ev(5, s + k * (H + G) + H);
    end
    push_ev(6, s + NP * (H + G));
    push_ev(7, s + NP * (H + G) + 1);
  endtask

  task automatic got_ev(input int k, input int c);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event_kind", k, -1);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", k, e.kind);
      check("event_cycle", c, e.cyc);
    end
  endtask

  logic [1:0] prev_rb = 2'b00;
  logic       prev_mcs = 1'b0, prev_done = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (prev_rb[i] && !resetb[i]) got_ev(2 * i, cyc);
        if (!prev_rb[i] && resetb[i]) got_ev(2 * i + 1, cyc);
      end
      if (!prev_mcs && mcs_sync) got_ev(4, cyc);
      if (prev_mcs && !mcs_sync) got_ev(5, cyc);
      if (!prev_done && bus.done) got_ev(6, cyc);
      if (prev_done && !bus.done) got_ev(7, cyc);
    end
    prev_rb   <= resetb;
    prev_mcs  <= mcs_sync;
    prev_done <= bus.done;
  end

  int gate_err = 0;

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.busy && !bus.done && (enable[0] || txnrx[0]) && resetb == 2'b00) gate_err++;
    end while (bus.busy && n < 400);
    if (bus.busy) check({tag, "_timeout"}, 1, 0);
  endtask

  task automatic issue(input bit r, input bit s, input logic [1:0] m, output int a);
    @(negedge clk);
    bus.cmd_reset = r;
    bus.cmd_sync  = s;
    bus.chip_mask = m;
    a = cyc + 1;
  endtask

  task automatic release_cmd();
    @(negedge clk);
    bus.cmd_reset = 1'b0;
    bus.cmd_sync  = 1'b0;
  endtask

  initial begin
    int a, a2, s;
    logic [15:0] old_status;
    bus.cmd_reset = 1'b0;
    bus.cmd_sync  = 1'b0;
    bus.chip_mask = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_resetb", resetb, 0);
    check("rst_mcs", mcs_sync, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_dropped", bus.cmd_dropped, 0);
    check("rst_enable", enable, 0);
    check("rst_ctl", ctl, 0);
    check("rst_status", status_out, 0);

    // Power-up sequence; enable/txnrx must stay gated while the chips are held or syncing.
    a = cyc;
    push_seq(a, 2'b11, 1);
    rst = 1'b0;
    gate_err = 0;
    do begin
      @(negedge clk);
      if (bus.busy && !bus.done && (enable[0] || txnrx[0])) gate_err++;
    end while ((bus.busy || cyc < a + 2) && cyc < a + 400);
    check("pwr_timeout", bus.busy, 0);
    check("pwr_gate", gate_err, 0);
    check("idle_enable", enable, 2'b01);
    check("idle_txnrx", txnrx, 2'b01);
    check("idle_resetb", resetb, 2'b11);

`ifdef RFIC_MCS_STATUS_IRQ_EN
    @(negedge clk);
    status_in = 16'h0800;
    repeat (3) @(negedge clk);
    check("irq_set", irq, 1);
    check("irq_src", irq_src, 16'h0800);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    check("irq_clr", irq, 0);
`endif

    old_status = status_in;
    @(negedge clk);
    status_in = 16'hA5C3;
    @(negedge clk);
    check("status_lat1", status_out, old_status);
    @(negedge clk);
    check("status_lat2", status_out, 16'hA5C3);

    // Reset only chip 1: chip 0 stays out of reset and keeps its enable.
    issue(1, 0, 2'b10, a);
    push_seq(a, 2'b10, 1);
    release_cmd();
    check("mask10_busy", bus.busy, 1);
    check("mask10_resetb", resetb, 2'b01);
    check("mask10_enable", enable, 2'b01);
    wait_idle("mask10");
    check("mask10_resetb_end", resetb, 2'b11);

    // Sync only; a second sync during the first gap is dropped.
    issue(0, 1, 2'b00, a);
    push_seq(a, 2'b00, 0);
    release_cmd();
    while (cyc < a + H + 1) @(negedge clk);
    bus.cmd_sync = 1'b1;
    @(negedge clk);
    bus.cmd_sync = 1'b0;
    check("drop_set", bus.cmd_dropped, 1);
    wait_idle("sync");
    check("drop_sticky", bus.cmd_dropped, 1);

    // cmd_reset with empty mask alongside cmd_sync: dropped clears, no resetb activity.
    issue(1, 1, 2'b00, a);
    push_seq(a, 2'b00, 1);
    release_cmd();
    check("drop_clr", bus.cmd_dropped, 0);

    // Abort during the second sync pulse with a full reset.
    s = a + R + P;
    while (cyc < s + H + G) @(negedge clk);
    check("abort_mcs_pre", mcs_sync, 1);
    bus.cmd_reset = 1'b1;
    bus.chip_mask = 2'b11;
    a2 = cyc + 1;
    purge(a2);
    push_ev(5, a2);
    push_seq(a2, 2'b11, 1);
    @(negedge clk);
    bus.cmd_reset = 1'b0;
    check("abort_mcs", mcs_sync, 0);
    check("abort_resetb", resetb, 2'b00);
    wait_idle("abort");
    check("abort_resetb_end", resetb, 2'b11);

    repeat (3) @(negedge clk);
    check("events_left", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rfic_mcs_seq.md
Name: rfic_mcs_seq

Overview:
- Parametrised control sequencer for NUM_RFIC AD9361-class transceivers; replaces per-chip static GPIO bit assignments and tied-off mcs_sync.
- Produces timed per-chip resetb release, multi-pulse MCS sync on a shared mcs_sync pin, and gated enable/txnrx/en_agc/ctl outputs.
- Synchronises CTRL_OUT status buses into the clk domain.
- Sits between the PS EMIO GPIO block and the RFIC pins in system_top.

Parameters:
- NUM_RFIC, 2, number of transceivers (1..4).
- STATUS_W, 8, CTRL_OUT width per chip.
- CTL_W, 4, CTRL_IN width per chip.
- RESET_CYCLES, 1000, clk cycles resetb is held low.
- POST_RESET_CYCLES, 5000, settle time after resetb rises.
- SYNC_PULSES, 3, number of MCS pulses per sync sequence (1..15).
- SYNC_HIGH_CYCLES, 8, mcs_sync high width.
- SYNC_GAP_CYCLES, 64, low gap between pulses.

Ports:
- clk  in  1  control clock.
- rst  in  1  synchronous, active-high reset.
- cmd_reset  in  1  single-cycle pulse: start reset sequence (auto-followed by sync).
- cmd_sync  in  1  single-cycle pulse: start sync sequence only.
- chip_mask  in  NUM_RFIC  chips targeted by cmd_reset; sampled on accept.
- sw_enable  in  NUM_RFIC  software ENABLE request per chip.
- sw_txnrx  in  NUM_RFIC  software TXNRX request per chip.
- sw_en_agc  in  NUM_RFIC  software EN_AGC per chip.
- sw_ctl  in  NUM_RFIC*CTL_W  CTRL_IN per chip, chip 0 in LSBs.
- status_in  in  NUM_RFIC*STATUS_W  asynchronous CTRL_OUT from chips.
- resetb  out  NUM_RFIC  active-low chip reset.
- mcs_sync  out  1  shared MCS pulse.
- enable  out  NUM_RFIC  gated ENABLE.
- txnrx  out  NUM_RFIC  gated TXNRX.
- en_agc  out  NUM_RFIC  gated EN_AGC.
- ctl  out  NUM_RFIC*CTL_W  gated CTRL_IN.
- status_out  out  NUM_RFIC*STATUS_W  synchronised status.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse when a sequence completes.
- cmd_dropped  out  1  sticky; set when cmd_sync is ignored; cleared by rst or accepted cmd_reset.

Behaviour:
- Reset values (rst high):
  - resetb all 0.
  - mcs_sync, enable, txnrx, en_agc, ctl, busy, done, cmd_dropped all 0.
  - status_out 0.
  - State RST_ASSERT with mask all-ones, so power-up runs a full sequence once rst deasserts.
- FSM states and transitions:
  - IDLE: cmd_reset -> RST_ASSERT; cmd_sync -> SYNC_HIGH.
  - RST_ASSERT: resetb[i]=0 for masked chips; unmasked chips keep their current value. After RESET_CYCLES -> RST_WAIT.
  - RST_WAIT: masked resetb=1. After POST_RESET_CYCLES -> SYNC_HIGH.
  - SYNC_HIGH: mcs_sync=1 for SYNC_HIGH_CYCLES, then increment pulse_cnt -> SYNC_GAP.
  - SYNC_GAP: mcs_sync=0 for SYNC_GAP_CYCLES. Then -> SYNC_HIGH if pulse_cnt<SYNC_PULSES, else DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Counters:
  - Single down-counter, width $clog2(max of the timing parameters)+1, loaded on state entry.
  - Each state lasts exactly its parameter in cycles.
  - pulse_cnt is 4 bits, cleared on entry to the sync phase.
- Outputs:
  - All outputs are registered.
  - A command accepted in cycle N changes outputs at cycle N+1; busy is 1 from N+1 to the DONE cycle inclusive.
- Gating: while a chip's resetb=0, or state is in RST_WAIT/SYNC_*, enable/txnrx/en_agc/ctl for that chip are forced 0. Otherwise they are registered copies of the sw_* inputs (1-cycle latency).
- Command priority:
  - cmd_reset while busy aborts the current sequence and restarts RST_ASSERT with the new mask; mcs_sync drops to 0 next cycle.
  - cmd_sync while busy is ignored and sets cmd_dropped.
  - cmd_reset and cmd_sync in the same cycle: cmd_reset wins; the sync is implicit in the reset sequence, so cmd_dropped is not set.
  - chip_mask=0 with cmd_reset: timing runs fully with no resetb change; sync still occurs.
- status_in: 2-flop synchroniser per bit; status_out latency 2 cycles. No cross-bit coherence is guaranteed.

Optional Feature:
- Macro RFIC_MCS_STATUS_IRQ_EN.
- When defined:
  - Adds input status_irq_mask (NUM_RFIC*STATUS_W) and outputs status_irq (1) and status_irq_src (NUM_RFIC*STATUS_W, sticky).
  - A rising edge on any synchronised, unmasked status bit sets its src bit; status_irq = |src.
  - Input status_irq_clr (1-cycle pulse) clears all src bits; a new edge in the same cycle wins.
  - src is held at 0 while the corresponding chip's resetb=0.
- When undefined: these ports and this logic are absent.

Decomposition:
- Package rfic_mcs_pkg: state enum (IDLE, RST_ASSERT, RST_WAIT, SYNC_HIGH, SYNC_GAP, DONE) and a counter-width helper function.
- Sub-module rfic_status_sync: a STATUS_W-bit 2-flop synchroniser plus the optional edge/sticky logic, instantiated NUM_RFIC times.

Test Plan:
- Power-up, with RESET_CYCLES=10, POST=20, SYNC_PULSES=3, HIGH=4, GAP=6:
  - resetb rises at cycle 10 after rst falls.
  - mcs_sync shows 3 pulses 4 cycles wide, 6 cycles apart.
  - done pulses once; busy then falls.
- cmd_reset with chip_mask=2'b10 in IDLE: resetb[1] low for 10 cycles; resetb[0] stays 1 throughout.
- cmd_sync during SYNC_GAP: ignored, cmd_dropped=1, pulse count still 3. A subsequent cmd_reset clears cmd_dropped.
- cmd_reset during the 2nd SYNC_HIGH: mcs_sync=0 next cycle, RST_ASSERT restarts, full 3 pulses follow.
- sw_enable=1, sw_txnrx=1 on chip 0: enable/txnrx=0 throughout the sequence; both equal 1 one cycle after IDLE while the inputs are held.
- RFIC_MCS_STATUS_IRQ_EN defined: status_in bit 3 of chip 1 goes 0->1 with mask=0 -> status_irq=1 within 3 cycles. status_irq_clr -> 0 next cycle.
